// File: rtl/intt_core_pkg.sv
// Shared constants, FSM encoding and zeta generator for the Kyber inverse NTT.
// Optional feature macro: INTT_SCALE_EN (final multiply by 128^-1 mod Q).
package intt_core_pkg;

    localparam int unsigned DWIDTH     = 12;
    localparam int unsigned KYBER_N    = 256;
    localparam int unsigned KYBER_Q    = 3329;
    localparam int unsigned KYBER_NINV = 3303;
    localparam int unsigned BARRETT_K  = 20159;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_SCALE,
        S_DONE
    } state_e;

    // 17^brv7(k) mod Q, evaluated only at elaboration time
    function automatic int unsigned zeta_calc(input int unsigned k);
        int unsigned e;
        int unsigned r;
        e = 0;
        for (int unsigned i = 0; i < 7; i++) begin
            e = e | (((k >> i) & 1) << (6 - i));
        end
        r = 1;
        for (int unsigned i = 0; i < e; i++) begin
            r = (r * 17) % KYBER_Q;
        end
        return r;
    endfunction

endpackage

// File: rtl/intt_core_zeta_rom.sv
// kyber_zeta_rom: 7-bit index -> 17^brv7(k) mod Q, shared with ntt_core.
module kyber_zeta_rom
    import intt_core_pkg::*;
(
    input  logic [6:0]        k,
    output logic [DWIDTH-1:0] zeta
);

    logic [DWIDTH-1:0] rom [128];

    for (genvar i = 0; i < 128; i++) begin : g_rom
        localparam int unsigned ZV = zeta_calc(i);
        assign rom[i] = DWIDTH'(ZV);
    end

    assign zeta = rom[k];

endmodule

// File: rtl/intt_core.sv
// Kyber inverse NTT engine: Gentleman-Sande butterflies, 2 cycles each, zetas walked 127 -> 1.
// Define INTT_SCALE_EN to append a 256-cycle pass multiplying every coefficient by 128^-1.
module intt_core
    import intt_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              busy,
    input  logic              ext_we,
    input  logic [7:0]        ext_addr,
    input  logic [DWIDTH-1:0] ext_data,
    output logic [DWIDTH-1:0] debug_out
);

    localparam logic signed [25:0] Q_S = 26'(KYBER_Q);
`ifdef INTT_SCALE_EN
    localparam state_e S_AFTER = S_SCALE;
`else
    localparam state_e S_AFTER = S_DONE;
`endif

    // Barrett with rounded-up constant: quotient may overshoot by one, hence the signed fix-up.
    function automatic logic [DWIDTH-1:0] barrett_reduce(input logic [23:0] x);
        logic [12:0]        qt;
        logic signed [25:0] r;
        qt = 13'((39'(x) * 39'(BARRETT_K)) >> 26);
        r  = signed'(26'(x)) - signed'(26'(qt * KYBER_Q));
        if (r < 26'sd0) begin
            r = r + Q_S;
        end else if (r >= Q_S) begin
            r = r - Q_S;
        end
        return DWIDTH'(r);
    endfunction

    logic [DWIDTH-1:0] mem_q [256];

    state_e            state_q, state_d;
    logic [2:0]        layer_q, layer_d;
    logic [6:0]        bf_q, bf_d;
    logic [6:0]        k_q, k_d;
    logic [DWIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic              done_q, done_d, busy_q, busy_d;
    logic [DWIDTH-1:0] debug_q, debug_d;
`ifdef INTT_SCALE_EN
    logic [7:0]        sidx_q, sidx_d;
`endif

    logic              start_ok, last_bf, group_end;
    logic [7:0]        len, mask, bf8, addr_lo, addr_hi, rd0_addr;
    logic [DWIDTH-1:0] rd0, rd1, zeta;
    logic [12:0]       sum_raw, diff_raw;
    logic [DWIDTH-1:0] sum_mod, diff_mod;
    logic              we0, we1;
    logic [7:0]        wa0, wa1;
    logic [DWIDTH-1:0] wd0, wd1;

    kyber_zeta_rom u_zeta_rom (
        .k    (k_q),
        .zeta (zeta)
    );

    // Butterfly index within a layer maps to j = group*2*len + offset.
    assign len       = 8'd1 << (layer_q + 3'd1);
    assign mask      = len - 8'd1;
    assign bf8       = {1'b0, bf_q};
    assign addr_lo   = ((bf8 & ~mask) << 1) | (bf8 & mask);
    assign addr_hi   = addr_lo + len;
    assign group_end = ((bf8 & mask) == mask);
    assign last_bf   = (bf_q == 7'h7F) && (layer_q == 3'd6);
    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef INTT_SCALE_EN
    assign rd0_addr = (state_q == S_SCALE) ? sidx_q : addr_lo;
`else
    assign rd0_addr = addr_lo;
`endif
    assign rd0 = mem_q[rd0_addr];
    assign rd1 = mem_q[addr_hi];

    assign sum_raw  = {1'b0, a_q} + {1'b0, b_q};
    assign sum_mod  = (sum_raw >= 13'(KYBER_Q)) ? DWIDTH'(sum_raw - 13'(KYBER_Q)) : DWIDTH'(sum_raw);
    assign diff_raw = {1'b0, b_q} + 13'(KYBER_Q) - {1'b0, a_q};
    assign diff_mod = (diff_raw >= 13'(KYBER_Q)) ? DWIDTH'(diff_raw - 13'(KYBER_Q)) : DWIDTH'(diff_raw);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            bf_q    <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            debug_q <= '0;
`ifdef INTT_SCALE_EN
            sidx_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            bf_q    <= bf_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            debug_q <= debug_d;
`ifdef INTT_SCALE_EN
            sidx_q  <= sidx_d;
`endif
        end
    end

    // Coefficient storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (rst && we0) mem_q[wa0] <= wd0;
        if (rst && we1) mem_q[wa1] <= wd1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RD;
            S_RD:           state_d = S_WR;
            S_WR:           state_d = last_bf ? S_AFTER : S_RD;
`ifdef INTT_SCALE_EN
            S_SCALE:        if (sidx_q == 8'hFF) state_d = S_DONE;
`endif
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        layer_d = layer_q;
        bf_d    = bf_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        done_d  = done_q;
        busy_d  = busy_q;
        debug_d = mem_q[ext_addr];
`ifdef INTT_SCALE_EN
        sidx_d  = sidx_q;
`endif
        we0 = 1'b0;
        wa0 = addr_lo;
        wd0 = sum_mod;
        we1 = 1'b0;
        wa1 = addr_hi;
        wd1 = barrett_reduce(24'(z_q) * 24'(diff_mod));
        case (state_q)
            S_IDLE, S_DONE: begin
                we0 = ext_we;
                wa0 = ext_addr;
                wd0 = ext_data;
                if (state_q == S_DONE) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_RD: begin
                a_d = rd0;
                b_d = rd1;
                z_d = zeta;
            end
            S_WR: begin
                we0  = 1'b1;
                we1  = 1'b1;
                bf_d = bf_q + 7'd1;
                if (bf_q == 7'h7F) layer_d = layer_q + 3'd1;
                if (group_end)     k_d     = k_q - 7'd1;
            end
`ifdef INTT_SCALE_EN
            S_SCALE: begin
                we0    = 1'b1;
                wa0    = sidx_q;
                wd0    = barrett_reduce(24'(rd0) * 24'(KYBER_NINV));
                sidx_d = sidx_q + 8'd1;
            end
`endif
            default: ;
        endcase
        if (start_ok) begin
            layer_d = '0;
            bf_d    = '0;
            k_d     = 7'h7F;
            done_d  = 1'b0;
            busy_d  = 1'b1;
`ifdef INTT_SCALE_EN
            sidx_d  = '0;
`endif
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign debug_out = debug_q;

endmodule

// File: tb/tb_intt_core.sv
// Self-checking bench for intt_core against an integer-arithmetic Kyber NTT/INTT model.
module tb_intt_core;

    localparam int unsigned Q = 3329;
`ifdef INTT_SCALE_EN
    localparam int LAT = 2049;
    localparam bit SCALE = 1'b1;
`else
    localparam int LAT = 1793;
    localparam bit SCALE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        ext_we = 1'b0;
    logic [7:0]  ext_addr = '0;
    logic [11:0] ext_data = '0;
    logic        done, busy;
    logic [11:0] debug_out;

    int errors = 0;
    int checks = 0;

    int unsigned vec   [256];
    int unsigned exp_v [256];

    intt_core dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_data  (ext_data),
        .debug_out (debug_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned zeta_of(input int unsigned k);
        int unsigned e = 0;
        int unsigned r = 1;
        for (int i = 0; i < 7; i++) e |= ((k >> i) & 1) << (6 - i);
        for (int unsigned i = 0; i < e; i++) r = (r * 17) % Q;
        return r;
    endfunction

    // Forward Kyber NTT (Cooley-Tukey) applied to vec in place
    task automatic model_ntt();
        int unsigned k = 1;
        for (int len = 128; len >= 2; len /= 2) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                int unsigned z = zeta_of(k);
                k++;
                for (int j = st; j < st + len; j++) begin
                    int unsigned t = (z * vec[j + len]) % Q;
                    vec[j + len] = (vec[j] + Q - t) % Q;
                    vec[j]       = (vec[j] + t) % Q;
                end
            end
        end
    endtask

    // Expected inverse transform of vec into exp_v
    task automatic model_intt();
        int unsigned k = 127;
        for (int i = 0; i < 256; i++) exp_v[i] = vec[i];
        for (int len = 2; len <= 128; len *= 2) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                int unsigned z = zeta_of(k);
                k--;
                for (int j = st; j < st + len; j++) begin
                    int unsigned t = exp_v[j];
                    exp_v[j]       = (t + exp_v[j + len]) % Q;
                    exp_v[j + len] = (z * ((exp_v[j + len] + Q - t) % Q)) % Q;
                end
            end
        end
        if (SCALE) begin
            for (int i = 0; i < 256; i++) exp_v[i] = (exp_v[i] * 3303) % Q;
        end
    endtask

    task automatic load_vec(input int n);
        for (int i = 0; i < n; i++) begin
            ext_we   = 1'b1;
            ext_addr = 8'(i);
            ext_data = 12'(vec[i]);
            tick();
        end
        ext_we = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 256; i++) begin
            ext_addr = 8'(i);
            tick();
            check($sformatf("%s[%0d]", tag, i), debug_out, exp_v[i]);
        end
    endtask

    // mode 0: plain run, 1: start+write injected at cycle 100, 2: reset at cycle 500
    task automatic run(input string tag, input int mode, input bit wr_last);
        int cnt = 0;
        start = 1'b1;
        if (wr_last) begin
            ext_we   = 1'b1;
            ext_addr = 8'd255;
            ext_data = 12'(vec[255]);
        end
        tick();
        start  = 1'b0;
        ext_we = 1'b0;
        while (cnt < 4000) begin
            tick();
            cnt++;
            if (cnt == 1) check({tag, "_busy"}, busy, 1);
            if (mode == 1 && cnt == 100) begin
                start = 1'b1;
                ext_we = 1'b1;
                ext_addr = 8'd5;
                ext_data = 12'd7;
                tick();
                cnt++;
                start = 1'b0;
                ext_we = 1'b0;
            end
            if (mode == 2 && cnt == 499) begin
                rst = 1'b0;
                tick();
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_done"}, done, 0);
                rst = 1'b1;
                return;
            end
            if (done) break;
        end
        check({tag, "_latency"}, cnt, LAT);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic rand_vec();
        for (int i = 0; i < 256; i++) vec[i] = $urandom_range(Q - 1, 0);
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        repeat (3) tick();
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_debug", debug_out, 0);
        rst = 1'b1;
        tick();

        // All-zero polynomial
        for (int i = 0; i < 256; i++) vec[i] = 0;
        model_intt();
        load_vec(256);
        run("zero", 0, 1'b0);
        check_mem("zero");

        // Round trip through the forward transform
        for (int i = 0; i < 256; i++) vec[i] = 0;
        vec[0] = 100;
        vec[1] = 50;
        model_ntt();
        load_vec(256);
        run("rt", 0, 1'b0);
        for (int i = 0; i < 256; i++) exp_v[i] = 0;
        exp_v[0] = SCALE ? 100 : (100 * 128) % Q;
        exp_v[1] = SCALE ? 50 : (50 * 128) % Q;
        check_mem("rt");

        // Random polynomials, second one loaded with write+start in the same cycle
        for (int r = 0; r < 2; r++) begin
            rand_vec();
            model_intt();
            load_vec(r == 0 ? 256 : 255);
            run($sformatf("rand%0d", r), 0, r == 1);
            check_mem($sformatf("rand%0d", r));
        end

        // Start and write while busy are ignored
        rand_vec();
        model_intt();
        load_vec(256);
        run("busy_prot", 1, 1'b0);
        check_mem("busy_prot");

        // Reset mid-run, then a fresh run
        rand_vec();
        load_vec(256);
        run("midrst", 2, 1'b0);
        rand_vec();
        model_intt();
        load_vec(256);
        run("after_rst", 0, 1'b0);
        check_mem("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
